// File: rtl/rv32i_alu_arbiter.sv
// rv32i_alu_arbiter: two-port arbiter and sequencer for the shared RV32I ALU.
// Grants the ALU to one requester, issues a one-cycle ALU update, then returns
// the registered ALU result on the owner's valid/ready response channel.
// Optional build macro ALU_ARB_ROUND_ROBIN_EN: ties alternate between the
// ports. When it is undefined, port 0 always wins a tie.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b     request channels, N = 0 (execute), 1 (secondary)
//   rspN_valid/ready            response handshake per port
//   rsp_y, rsp_err              shared response payload
//   alu_en, alu_a, alu_b, alu_op  ALU drive; alu_y  registered ALU result
module rv32i_alu_arbiter #(
    parameter int unsigned OP_W = 14,
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OP_W-1:0] req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OP_W-1:0] req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp_y,
    output logic            rsp_err,
    output logic            alu_en,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [XLEN-1:0] alu_y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state_q;
    logic            ready_en_q;   // high exactly while IDLE and out of reset
    logic            owner_q;      // port that owns the in-flight operation
    logic            err_q;        // in-flight operation had an illegal op
    logic            gnt1;         // arbitration picks port 1
    logic            xfer;
    logic            sel_illegal;
    logic            rsp_hs;
    logic [OP_W-1:0] sel_op;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;

    // Arbitration on this cycle's valids; a tie goes to port 0 unless alternating
`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_grant_q;
    always_comb gnt1 = req1_valid && (!req0_valid || !last_grant_q);
`else
    always_comb gnt1 = req1_valid && !req0_valid;
`endif

    // Ready depends on valid here: only the selected requester sees ready
    assign req0_ready = ready_en_q && req0_valid && !gnt1;
    assign req1_ready = ready_en_q && gnt1;
    assign xfer       = ready_en_q && (req0_valid || req1_valid);

    assign sel_op      = gnt1 ? req1_op : req0_op;
    assign sel_a       = gnt1 ? req1_a  : req0_a;
    assign sel_b       = gnt1 ? req1_b  : req0_b;
    // More than one bit set: clearing the lowest set bit leaves something behind
    assign sel_illegal = |(sel_op & (sel_op - OP_W'(1)));

    assign rsp_hs = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    // alu_y is already registered and frozen while alu_en is low, so the
    // response payload is a plain mux that stays stable under backpressure
    assign rsp_y = ((rsp0_valid || rsp1_valid) && !err_q) ? alu_y : '0;

    // Sequencer state and registered ALU/response drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ready_en_q   <= 1'b0;
            owner_q      <= 1'b0;
            err_q        <= 1'b0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp_err      <= 1'b0;
            alu_en       <= 1'b0;
            alu_op       <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    ready_en_q <= 1'b1;
                    alu_en     <= 1'b0;
                    alu_op     <= '0;
                    if (xfer) begin
                        ready_en_q   <= 1'b0;
                        owner_q      <= gnt1;
                        err_q        <= sel_illegal;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                        last_grant_q <= gnt1;
`endif
                        if (sel_illegal) begin
                            // Skip the ALU entirely; respond with an error next cycle
                            state_q    <= RESP;
                            rsp0_valid <= !gnt1;
                            rsp1_valid <= gnt1;
                            rsp_err    <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            alu_en  <= 1'b1;
                            alu_op  <= sel_op;
                            alu_a   <= sel_a;
                            alu_b   <= sel_b;
                        end
                    end
                end
                ISSUE: begin
                    alu_en     <= 1'b0;
                    alu_op     <= '0;
                    state_q    <= RESP;
                    rsp0_valid <= !owner_q;
                    rsp1_valid <= owner_q;
                    rsp_err    <= err_q;
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        rsp_err    <= 1'b0;
                        err_q      <= 1'b0;
                        ready_en_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    rsp_err    <= 1'b0;
                    alu_en     <= 1'b0;
                    alu_op     <= '0;
                    ready_en_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_alu_arbiter.sv
// tb_rv32i_alu_arbiter: directed bench for rv32i_alu_arbiter with a small
// registered ALU model, a response scoreboard and cycle-level timing checks.
// Honours ALU_ARB_ROUND_ROBIN_EN for the expected contention grant order.
module tb_rv32i_alu_arbiter;

    localparam int unsigned OP_W = 14;
    localparam logic [OP_W-1:0] OP_ADD  = 14'h0001;
    localparam logic [OP_W-1:0] OP_SUB  = 14'h0002;
    localparam logic [OP_W-1:0] OP_SLT  = 14'h0004;
    localparam logic [OP_W-1:0] OP_SLTU = 14'h0008;
    localparam logic [OP_W-1:0] OP_SLL  = 14'h0080;
    localparam logic [OP_W-1:0] OP_BAD  = 14'h0003;
    localparam logic [OP_W-1:0] OP_NONE = 14'h0000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [OP_W-1:0] req0_op, req1_op;
    logic [31:0]     req0_a, req0_b, req1_a, req1_b;
    logic            rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0]     rsp_y;
    logic            rsp_err;
    logic            alu_en;
    logic [31:0]     alu_a, alu_b, alu_y;
    logic [OP_W-1:0] alu_op;

    typedef struct packed {
        logic        port;
        logic [31:0] y;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    rv32i_alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_y      (rsp_y),
        .rsp_err    (rsp_err),
        .alu_en     (alu_en),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_y      (alu_y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered ALU stand-in: updates only when alu_en is high
    function automatic logic [31:0] alu_model(input logic [OP_W-1:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0] y;
        y = '0;
        if (op[0])  y = a + b;
        if (op[1])  y = a - b;
        if (op[2])  y = 32'($signed(a) < $signed(b));
        if (op[3])  y = 32'(a < b);
        if (op[4])  y = a ^ b;
        if (op[5])  y = a | b;
        if (op[6])  y = a & b;
        if (op[7])  y = a << b[4:0];
        if (op[8])  y = a >> b[4:0];
        if (op[9])  y = 32'($signed(a) >>> b[4:0]);
        if (op[10]) y = 32'(a == b);
        if (op[11]) y = 32'(a != b);
        if (op[12]) y = 32'($signed(a) >= $signed(b));
        if (op[13]) y = 32'(a >= b);
        return y;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      alu_y <= '0;
        else if (alu_en) alu_y <= alu_model(alu_op, alu_a, alu_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every response handshake pops one expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp0_valid && rsp1_valid) begin
                n_checks++;
                n_errors++;
                $display("FAIL rsp_owner: both rsp valids high (t=%0t)", $time);
            end
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rsp_unexpected: port %0d y %h, no response required",
                             rsp1_valid, rsp_y);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_port", 32'(rsp1_valid), 32'(mon_e.port));
                    chk("rsp_y", rsp_y, mon_e.y);
                    chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic p, input logic [31:0] y, input logic e);
        exp_t x;
        x.port = p;
        x.y    = y;
        x.err  = e;
        sb.push_back(x);
    endtask

    // Returns the granted port at the negedge of the transfer cycle, -1 on timeout
    task automatic wait_any(output int p);
        p = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_ready) begin p = 0; return; end
            if (req1_ready) begin p = 1; return; end
        end
        n_checks++;
        n_errors++;
        $display("FAIL grant_timeout: no request ready within 20 cycles (t=%0t)", $time);
    endtask

    // One legal op with full issue/response timing checks
    task automatic single(input logic p, input logic [OP_W-1:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] y);
        int g;
        if (p) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
        else   begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
        push(p, y, 1'b0);
        wait_any(g);
        chk("single_grant", 32'(g), 32'(p));
        chk("single_xfer_alu_en", 32'(alu_en), 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("issue_alu_en", 32'(alu_en), 32'd1);
        chk("issue_alu_op", 32'(alu_op), 32'(op));
        chk("issue_alu_a", alu_a, a);
        chk("issue_alu_b", alu_b, b);
        chk("issue_no_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        @(negedge clk);
        chk("resp_alu_en", 32'(alu_en), 32'd0);
        chk("resp_alu_op", 32'(alu_op), 32'd0);
        chk("resp_valid", 32'({rsp1_valid, rsp0_valid}), p ? 32'd2 : 32'd1);
        chk("resp_y_direct", rsp_y, y);
        tick();
    endtask

    task automatic backpressure(input logic [OP_W-1:0] op, input logic [31:0] y);
        int g;
        req1_op = op; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_valid = 1'b1;
        push(1'b1, y, 1'b0);
        wait_any(g);
        chk("bp_grant", 32'(g), 32'd1);
        tick();
        req1_valid = 1'b0;
        rsp1_ready = 1'b0;
        req0_op = OP_ADD; req0_a = 32'd1; req0_b = 32'd1; req0_valid = 1'b1;
        @(negedge clk);
        chk("bp_issue_req0_ready", 32'(req0_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_stall_valid", 32'(rsp1_valid), 32'd1);
            chk("bp_stall_y", rsp_y, y);
            chk("bp_stall_err", 32'(rsp_err), 32'd0);
            chk("bp_stall_req0_ready", 32'(req0_ready), 32'd0);
            chk("bp_stall_alu_en", 32'(alu_en), 32'd0);
        end
        tick();
        rsp1_ready = 1'b1;
        req0_valid = 1'b0;
        @(negedge clk);
        tick();
    endtask

    initial begin
        int g;
        int last;
        int exp_order[3];
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = OP_ADD; req1_op = OP_ADD;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset state, with requests pending to make ready meaningful
        #2;
        chk("rst_req_ready", 32'({req1_ready, req0_ready}), 32'd0);
        chk("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        chk("rst_rsp_y", rsp_y, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_alu_en", 32'(alu_en), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_ab", alu_a | alu_b, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single add on port 0: 5 + 7
        single(1'b0, OP_ADD, 32'd5, 32'd7, 32'd12);

        // Continuous contention for three grants
`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0};
`else
        exp_order = '{0, 0, 0};
`endif
        for (int i = 0; i < 3; i++) push(exp_order[i] == 1, exp_order[i] == 1 ? 32'd16 : 32'd7, 1'b0);
        req0_op = OP_SUB; req0_a = 32'd10; req0_b = 32'd3; req0_valid = 1'b1;
        req1_op = OP_SLL; req1_a = 32'd1;  req1_b = 32'd4; req1_valid = 1'b1;
        last = 0;
        for (int i = 0; i < 3; i++) begin
            wait_any(g);
            chk("contention_grant", 32'(g), 32'(exp_order[i]));
            if (i > 0) chk("contention_spacing", 32'(cyc - last), 32'd3);
            last = cyc;
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) tick();

        // Backpressure: sltu 0xFFFFFFFF < 1 is 0; slt -1 < 1 is 1
        backpressure(OP_SLTU, 32'd0);
        backpressure(OP_SLT, 32'd1);

        // Illegal op: error response one cycle after transfer, ALU untouched
        req0_op = OP_BAD; req0_a = 32'd9; req0_b = 32'd9; req0_valid = 1'b1;
        push(1'b0, 32'd0, 1'b1);
        wait_any(g);
        chk("illegal_grant", 32'(g), 32'd0);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("illegal_alu_en", 32'(alu_en), 32'd0);
        chk("illegal_rsp_valid", 32'(rsp0_valid), 32'd1);
        chk("illegal_rsp_err", 32'(rsp_err), 32'd1);
        chk("illegal_rsp_y", rsp_y, 32'd0);
        @(negedge clk);
        chk("illegal_after_valid", 32'(rsp0_valid), 32'd0);
        chk("illegal_after_alu_en", 32'(alu_en), 32'd0);
        chk("illegal_after_err", 32'(rsp_err), 32'd0);
        tick();

        // Zero op on port 1 after a nonzero ALU result
        single(1'b1, OP_NONE, 32'd123, 32'd456, 32'd0);

        // Reset during ISSUE discards the operation
        req0_op = OP_ADD; req0_a = 32'd2; req0_b = 32'd3; req0_valid = 1'b1;
        wait_any(g);
        chk("rstmid_grant", 32'(g), 32'd0);
        tick();
        req0_op = OP_ADD; req0_a = 32'd9; req0_b = 32'd1;
        req1_op = OP_SLL; req1_a = 32'd1; req1_b = 32'd4; req1_valid = 1'b1;
        chk("rstmid_pre_alu_en", 32'(alu_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_alu_en", 32'(alu_en), 32'd0);
        chk("rstmid_alu_op", 32'(alu_op), 32'd0);
        chk("rstmid_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        chk("rstmid_req_ready", 32'({req1_ready, req0_ready}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(1'b0, 32'd10, 1'b0);
        wait_any(g);
        chk("rstmid_first_tie", 32'(g), 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (5) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv32i_alu_arbiter.md
# rv32i_alu_arbiter

Two-port arbiter and sequencer for the shared RV32I execute-stage ALU. It accepts operation requests from two requesters (port 0: core execute stage; port 1: secondary client such as address generation or debug), grants the ALU to one of them, and drives the ALU's operands, one-hot operation flags and update enable. It returns the registered ALU result to the owning requester over a valid/ready response channel. It sits directly between the requesters and the ALU and is the only block that drives the ALU inputs.

## Interface
- OP_W, 14, width of one-hot op vector. Bit order: [0] add, [1] sub, [2] slt, [3] sltu, [4] xor, [5] or, [6] and, [7] sll, [8] srl, [9] sra, [10] eq, [11] neq, [12] ge, [13] geu.

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req0_valid / req1_valid  in  1  request valid per port
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&&ready
- req0_op / req1_op  in  OP_W  one-hot operation
- req0_a / req1_a  in  32  operand a (rs1 or pc)
- req0_b / req1_b  in  32  operand b (rs2 or imm)
- rsp0_valid / rsp1_valid  out  1  response valid to the owning port
- rsp0_ready / rsp1_ready  in  1  response consumed when valid&&ready
- rsp_y  out  32  result, shared by both response channels
- rsp_err  out  1  illegal op (more than one op bit set), qualified by rspN_valid
- alu_en  out  1  ALU output update enable
- alu_a, alu_b  out  32  ALU operands
- alu_op  out  OP_W  ALU operation flags
- alu_y  in  32  registered ALU result

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE:
  - reqN_ready = 1 only for the port selected by arbitration; the other port's ready = 0.
  - On transfer, latch op/a/b and owner into internal registers, and update last_grant.
  - If the op has more than one bit set, go to RESP with err = 1. Otherwise go to ISSUE.
  - An all-zero op is legal; the ALU yields 0.
- ISSUE: exactly one cycle. alu_en = 1, alu_a/alu_b/alu_op = latched values. Next state is RESP.
- RESP:
  - rspN_valid = 1 for the owner only.
  - rsp_y = alu_y, or 0 when err.
  - rsp_err = err.
  - Hold until rspN_ready, then go to IDLE.
- Outside ISSUE: alu_en = 0 and alu_op = 0, so the ALU holds its result. alu_a/alu_b hold their last values.
- Both ready outputs are 0 in ISSUE and RESP (single outstanding operation).
- Arbitration is performed in IDLE only, on the reqN_valid seen that cycle.
- A requester must hold valid and its payload stable until ready. The arbiter does not check this.

## Timing
- Request transfer in cycle T:
  - legal op: alu_en high in T+1, rspN_valid first high in T+2.
  - illegal op: no alu_en; rspN_valid first high in T+1.
- Minimum throughput: one legal operation per 3 cycles, and one per 2 cycles for illegal ops. The next transfer occurs at the earliest in the cycle after the response handshake.
- Response backpressure: rsp_y, rsp_err and rspN_valid are held stable until the handshake completes.
- Reset values:
  - all outputs 0: reqN_ready, rspN_valid, rsp_y, rsp_err, alu_en, alu_a, alu_b, alu_op
  - state = IDLE; last_grant = 1, so port 0 wins the first tie.
- Reset asserted mid-operation (any state): the in-flight op is discarded, outputs go to reset values asynchronously, and no response is produced after reset release.

## Configuration
- ALU_ARB_ROUND_ROBIN_EN defined: on a tie, grant the port not equal to last_grant (strict alternation under continuous contention).
- Undefined: fixed priority. Port 0 always wins a tie, and last_grant is unused.
- Single-requester behaviour is identical in both builds.

## Test plan
- Single op: port 0 requests add, a=5, b=7, transfer at T -> alu_en high only in T+1, rsp0_valid at T+2, rsp_y=12, rsp_err=0, rsp1_valid=0 throughout.
- Contention: both ports hold continuous requests (port 0 sub 10-3, port 1 sll 1<<4) for three grants.
  - with macro: grant order 0,1,0; rsp_y = 7, 16, 7.
  - without macro: grant order 0,0,0.
- Backpressure: port 1 requests sltu a=0xFFFFFFFF, b=1; rsp1_ready is held low 4 cycles -> rsp1_valid and rsp_y=0 stay stable, req0_ready=0, alu_en=0 during the stall. Repeat with slt -> rsp_y=1.
- Illegal op: port 0 op=0x0003 -> alu_en never high, rsp0_valid at T+1 with rsp_err=1 and rsp_y=0, then IDLE.
- Reset mid-ISSUE: assert rst_n low during ISSUE -> alu_en, rsp*_valid and req*_ready go to 0 immediately. After release, port 0 wins the first tie, and no stale response appears.
- Zero op: port 1 op=0 -> alu_en pulse in T+1, rsp_y=0, rsp_err=0.
